pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RISC-V core.
- Merges hazard and event sources into one set of per-stage stall/flush controls: load-use request from the hazard detection unit, EX-stage branch redirect, MEM-stage data-memory wait, and fixed-latency mul/div occupancy.
- Holds a small FSM for multi-cycle events and keeps stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_perf_cnt.sv | 27 ++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states,
// the per-stage stall/flush bundle and its fixed patterns.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_BUSY = 2'd2
  } state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
  } pipe_ctl_t;

  localparam int MDU_LATENCY_DEF = 4;

  localparam pipe_ctl_t CTL_NONE = '0;
  localparam pipe_ctl_t CTL_MEM  = 7'b1111_000;
  localparam pipe_ctl_t CTL_MDU  = 7'b1110_001;
  localparam pipe_ctl_t CTL_BR   = 7'b0000_110;
  localparam pipe_ctl_t CTL_LU   = 7'b1100_010;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Wrapping performance counter with enable.
// Ports: clk, rst_n, en (count this cycle), cnt (value).
module perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges load-use, branch, dmem wait and
// mul/div occupancy into per-stage stall/flush plus perf counters.
// Ports: clk, rst_n, load_use, branch_taken, dmem_req, dmem_ready,
// mdu_start in; stall_*/flush_* controls, stall_cycles, flush_events out.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             mdu_start,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int   MW        = $clog2(MDU_LATENCY + 1);
  localparam logic MDU_MULTI = (MDU_LATENCY > 1);
  localparam logic MDU_SHORT = (MDU_LATENCY == 2);

  state_e          state_q, state_d;
  logic [MW-1:0]   mdu_cnt_q, mdu_cnt_d;
  logic            rel_q, rel_d;
  pipe_ctl_t       ctl;
  pipe_ctl_t       ctl_o;

  logic eval;
  logic mem_go;
  logic hold_wait;
  logic busy;
  logic mdu_go;
  logic br_go;
  logic lu_go;

  // The dmem ready cycle in MEM_WAIT re-runs the RUN rules
  // with the memory rule forced false.
  assign eval      = (state_q == RUN) ||
                     (state_q == MEM_WAIT && dmem_ready);
  assign mem_go    = (state_q == RUN) && dmem_req && !dmem_ready;
  assign hold_wait = (state_q == MEM_WAIT) && !dmem_ready;
  assign busy      = (state_q == MDU_BUSY);
  // rel_q masks the still-high mdu_start of the departing op.
  assign mdu_go    = eval && !mem_go && mdu_start &&
                     !rel_q && MDU_MULTI;
  assign br_go     = eval && !mem_go && !mdu_go && branch_taken;
  assign lu_go     = eval && !mem_go && !mdu_go &&
                     !branch_taken && load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
      rel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      rel_q     <= rel_d;
    end
  end

  // Busy cycles = MDU_LATENCY-2; leave when the count
  // reaches zero at this edge.
  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    rel_d     = 1'b0;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_go || hold_wait) begin
          state_d = MEM_WAIT;
        end else if (mdu_go) begin
          mdu_cnt_d = MW'(MDU_LATENCY - 2);
          if (MDU_SHORT) begin
            state_d = RUN;
            rel_d   = 1'b1;
          end else begin
            state_d = MDU_BUSY;
          end
        end else begin
          state_d = RUN;
        end
      end
      MDU_BUSY: begin
        mdu_cnt_d = mdu_cnt_q - MW'(1);
        if (mdu_cnt_q <= MW'(1)) begin
          state_d   = RUN;
          mdu_cnt_d = '0;
          rel_d     = 1'b1;
        end
      end
      default: begin
        state_d   = RUN;
        mdu_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    ctl = CTL_NONE;
    unique case (1'b1)
      mem_go, hold_wait: ctl = CTL_MEM;
      busy, mdu_go:      ctl = CTL_MDU;
      br_go:             ctl = CTL_BR;
      lu_go:             ctl = CTL_LU;
      default:           ctl = CTL_NONE;
    endcase
  end

  // Force all controls low while reset is asserted.
  assign ctl_o = rst_n ? ctl : CTL_NONE;

  assign stall_pc     = ctl_o.stall_pc;
  assign stall_if_id  = ctl_o.stall_if_id;
  assign stall_id_ex  = ctl_o.stall_id_ex;
  assign stall_ex_mem = ctl_o.stall_ex_mem;
  assign flush_if_id  = ctl_o.flush_if_id;
  assign flush_id_ex  = ctl_o.flush_id_ex;
  assign flush_ex_mem = ctl_o.flush_ex_mem;

  perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctl_o.stall_pc),
    .cnt   (stall_cycles)
  );

  perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (br_go),
    .cnt   (flush_events)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus
// random traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int LAT = 4;

  localparam logic [6:0] E_NONE = 7'b0000_000;
  localparam logic [6:0] E_MEM  = 7'b1111_000;
  localparam logic [6:0] E_MDU  = 7'b1110_001;
  localparam logic [6:0] E_BR   = 7'b0000_110;
  localparam logic [6:0] E_LU   = 7'b1100_010;

  logic        clk;
  logic        rst_n;
  logic        load_use;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        mdu_start;
  logic        stall_pc;
  logic        stall_if_id;
  logic        stall_id_ex;
  logic        stall_ex_mem;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
  logic [6:0]  ctl;

  int checks;
  int failures;

  // behavioural model: plain counters of what is pending
  bit          m_wait;
  int          m_busy_left;
  bit          m_release;
  int unsigned m_sc;
  int unsigned m_fe;

  logic [6:0]  exp_ctl;
  int unsigned exp_sc;
  int unsigned exp_fe;

  pipe_ctrl #(.MDU_LATENCY(LAT), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .mdu_start    (mdu_start),
    .stall_pc     (stall_pc),
    .stall_if_id  (stall_if_id),
    .stall_id_ex  (stall_id_ex),
    .stall_ex_mem (stall_ex_mem),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_ex_mem (flush_ex_mem),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  assign ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                flush_if_id, flush_id_ex, flush_ex_mem};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_wait      = 1'b0;
    m_busy_left = 0;
    m_release   = 1'b0;
    m_sc        = 0;
    m_fe        = 0;
  endtask

  // One cycle: drive after the edge, evaluate model at negedge.
  task automatic step(input bit lu, input bit br, input bit dq,
                      input bit dr, input bit ms);
    logic [6:0] e;
    bit nrel;
    @(posedge clk);
    #1;
    load_use     = lu;
    branch_taken = br;
    dmem_req     = dq;
    dmem_ready   = dr;
    mdu_start    = ms;
    @(negedge clk);
    exp_sc = m_sc;
    exp_fe = m_fe;
    e      = E_NONE;
    nrel   = 1'b0;
    if (m_busy_left > 0) begin
      e = E_MDU;
      m_busy_left--;
      if (m_busy_left == 0) nrel = 1'b1;
    end else if (m_wait && !dr) begin
      e = E_MEM;
    end else if (!m_wait && dq && !dr) begin
      e      = E_MEM;
      m_wait = 1'b1;
    end else begin
      m_wait = 1'b0;
      if (ms && !m_release && LAT > 1) begin
        e           = E_MDU;
        m_busy_left = LAT - 2;
        if (m_busy_left == 0) nrel = 1'b1;
      end else if (br) begin
        e = E_BR;
        m_fe++;
      end else if (lu) begin
        e = E_LU;
      end
    end
    if (e[6]) m_sc++;
    m_release = nrel;
    exp_ctl   = e;
  endtask

  task automatic do_reset();
    load_use     = 1'b0;
    branch_taken = 1'b0;
    dmem_req     = 1'b0;
    dmem_ready   = 1'b0;
    mdu_start    = 1'b0;
    rst_n        = 1'b0;
    #1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ctl !== E_NONE) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, E_NONE);
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
               stall_cycles, flush_events);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (ctl !== E_NONE) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=%b", ctl, E_NONE);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    step(1, 0, 0, 0, 0);
    checks++;
    if (ctl !== E_LU || exp_ctl !== E_LU) begin
      failures++;
      $display("FAIL load_use got=%b exp=%b", ctl, E_LU);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (ctl !== E_NONE || stall_cycles !== 32'd1) begin
      failures++;
      $display("FAIL load_use_after got=%b/%0d exp=%b/1",
               ctl, stall_cycles, E_NONE);
    end
  endtask

  task automatic test_branch_over_lu();
    do_reset();
    step(1, 1, 0, 0, 0);
    checks++;
    if (ctl !== E_BR) begin
      failures++;
      $display("FAIL branch_lu got=%b exp=%b", ctl, E_BR);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (flush_events !== 32'd1 || stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL branch_cnt got=fe%0d sc%0d exp=fe1 sc0",
               flush_events, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 1);
      checks++;
      if (ctl !== E_MEM) begin
        failures++;
        $display("FAIL mem_wait[%0d] got=%b exp=%b", i, ctl, E_MEM);
      end
    end
    step(0, 0, 1, 1, 0);
    checks++;
    if (ctl !== E_NONE) begin
      failures++;
      $display("FAIL mem_ready got=%b exp=%b", ctl, E_NONE);
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (ctl !== E_LU || stall_cycles !== 32'd3) begin
      failures++;
      $display("FAIL mem_after got=%b/%0d exp=%b/3",
               ctl, stall_cycles, E_LU);
    end
  endtask

  task automatic test_mdu();
    int n_stall;
    do_reset();
    n_stall = 0;
    for (int i = 0; i < LAT; i++) begin
      step(0, 0, 0, 0, 1);
      n_stall += int'(stall_pc);
      checks++;
      if (ctl !== exp_ctl) begin
        failures++;
        $display("FAIL mdu[%0d] got=%b exp=%b", i, ctl, exp_ctl);
      end
    end
    checks++;
    if (n_stall != LAT - 1 || ctl !== E_NONE) begin
      failures++;
      $display("FAIL mdu_len got=%0d/%b exp=%0d/%b",
               n_stall, ctl, LAT - 1, E_NONE);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (stall_cycles !== 32'(LAT - 1)) begin
      failures++;
      $display("FAIL mdu_cnt got=%0d exp=%0d", stall_cycles, LAT - 1);
    end
  endtask

  task automatic test_mem_then_mdu();
    do_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 1);
    checks++;
    if (ctl !== E_MDU) begin
      failures++;
      $display("FAIL mem_mdu_entry got=%b exp=%b", ctl, E_MDU);
    end
    for (int i = 0; i < LAT - 1; i++) step(0, 0, 0, 0, 1);
    checks++;
    if (ctl !== E_NONE) begin
      failures++;
      $display("FAIL mem_mdu_release got=%b exp=%b", ctl, E_NONE);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (stall_cycles !== 32'd5) begin
      failures++;
      $display("FAIL mem_mdu_cnt got=%0d exp=5", stall_cycles);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== E_NONE) begin
      failures++;
      $display("FAIL async_rst_ctl got=%b exp=%b", ctl, E_NONE);
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      failures++;
      $display("FAIL async_rst_cnt got=%0d/%0d exp=0/0",
               stall_cycles, flush_events);
    end
    do_reset();
    step(0, 0, 0, 0, 0);
    checks++;
    if (ctl !== E_NONE) begin
      failures++;
      $display("FAIL async_rst_idle got=%b exp=%b", ctl, E_NONE);
    end
  endtask

  task automatic test_random();
    bit lu, br, dq, dr, ms;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      lu = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 4) == 0);
      dq = ($urandom_range(0, 2) == 0);
      dr = ($urandom_range(0, 1) == 0);
      ms = ($urandom_range(0, 4) == 0);
      step(lu, br, dq, dr, ms);
      checks++;
      if (ctl !== exp_ctl) begin
        failures++;
        $display("FAIL rnd_ctl[%0d] got=%b exp=%b", i, ctl, exp_ctl);
      end
      checks++;
      if (stall_cycles !== exp_sc || flush_events !== exp_fe) begin
        failures++;
        $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d",
                 i, stall_cycles, flush_events, exp_sc, exp_fe);
      end
      checks++;
      if ((stall_if_id & flush_if_id) | (stall_id_ex & flush_id_ex) |
          (stall_ex_mem & flush_ex_mem)) begin
        failures++;
        $display("FAIL rnd_excl[%0d] got=%b exp=no overlap", i, ctl);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    model_clear();
    test_reset();
    test_load_use();
    test_branch_over_lu();
    test_mem_wait();
    test_mdu();
    test_mem_then_mdu();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
